// File: rtl/phys_free_list_pkg.sv
// Shared rename-stage definitions: default register-file sizes and the physical tag type.
`default_nettype none
package phys_free_list_pkg;
  localparam int NUM_REG  = 8;   // architectural registers
  localparam int NUM_PREG = 16;  // physical registers
  localparam int PTAG_W   = $clog2(NUM_PREG);
  typedef logic [PTAG_W-1:0] phys_tag_t;
endpackage
`default_nettype wire

// File: rtl/phys_free_list_if.sv
// Rename/commit-side bundle for the physical register free list.
`default_nettype none
interface phys_free_list_if
  import phys_free_list_pkg::*;
#(
  parameter int NUM_PHYS = NUM_PREG,
  parameter int NUM_ARCH = NUM_REG
);
  localparam int TAG_W = $clog2(NUM_PHYS);
  localparam int CNT_W = $clog2(NUM_PHYS - NUM_ARCH + 1);

  logic             alloc_req;
  logic             alloc_valid;
  logic [TAG_W-1:0] alloc_tag;
  logic             ret_valid;
  logic [TAG_W-1:0] ret_tag;
  logic             commit_alloc;
  logic             recover;
  logic [CNT_W-1:0] free_count;
  logic             err_overflow;
  logic             err_underflow;

  modport master (
    output alloc_req, ret_valid, ret_tag, commit_alloc, recover,
    input  alloc_valid, alloc_tag, free_count, err_overflow, err_underflow
  );

  modport slave (
    input  alloc_req, ret_valid, ret_tag, commit_alloc, recover,
    output alloc_valid, alloc_tag, free_count, err_overflow, err_underflow
  );
endinterface
`default_nettype wire

// File: rtl/phys_free_list.sv
// Circular free list of physical tags with a speculative head and a commit head for squash recovery.
`default_nettype none
module phys_free_list
  import phys_free_list_pkg::*;
#(
  parameter int NUM_PHYS = NUM_PREG,
  parameter int NUM_ARCH = NUM_REG
) (
  input  wire logic        clk,
  input  wire logic        rst,
  phys_free_list_if.slave  fl
);
  localparam int TAG_W   = $clog2(NUM_PHYS);
  localparam int FL_SIZE = NUM_PHYS - NUM_ARCH;
  localparam int CNT_W   = $clog2(FL_SIZE + 1);
  localparam int PTR_W   = (FL_SIZE > 1) ? $clog2(FL_SIZE) : 1;

  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FL_SIZE);

  // Wrap explicitly so non-power-of-two list sizes work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FL_SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [TAG_W-1:0] r_buf [FL_SIZE];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_chead;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_spec_cnt;
  logic [CNT_W-1:0] r_arch_cnt;
  logic             r_err_overflow;
  logic             r_err_underflow;

  logic             w_fire;
  logic             w_ret_ok;
  logic             w_commit_ok;
  logic [PTR_W-1:0] w_chead_nxt;
  logic [CNT_W-1:0] w_arch_nxt;

  assign w_fire      = fl.alloc_req && (r_spec_cnt != '0) && !fl.recover;
  assign w_ret_ok    = fl.ret_valid && (r_arch_cnt != C_FULL);
  // Entries between chead and head are allocated but not yet committed.
  assign w_commit_ok = fl.commit_alloc && (r_arch_cnt > r_spec_cnt);
  assign w_chead_nxt = w_commit_ok ? ptr_inc(r_chead) : r_chead;
  assign w_arch_nxt  = r_arch_cnt + CNT_W'(w_ret_ok) - CNT_W'(w_commit_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        r_buf[i] <= TAG_W'(NUM_ARCH + i);
      end
      r_head          <= '0;
      r_chead         <= '0;
      r_tail          <= '0;
      r_spec_cnt      <= C_FULL;
      r_arch_cnt      <= C_FULL;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      if (w_ret_ok) begin
        r_buf[r_tail] <= fl.ret_tag;
        r_tail        <= ptr_inc(r_tail);
      end
      r_chead    <= w_chead_nxt;
      r_arch_cnt <= w_arch_nxt;
      if (fl.recover) begin
        r_head     <= w_chead_nxt;
        r_spec_cnt <= w_arch_nxt;
      end else begin
        if (w_fire) begin
          r_head <= ptr_inc(r_head);
        end
        r_spec_cnt <= r_spec_cnt + CNT_W'(w_ret_ok) - CNT_W'(w_fire);
      end
      if (fl.ret_valid && !w_ret_ok) begin
        r_err_overflow <= 1'b1;
      end
      if (fl.commit_alloc && !w_commit_ok) begin
        r_err_underflow <= 1'b1;
      end
    end
  end

  assign fl.alloc_valid   = (r_spec_cnt != '0);
  assign fl.alloc_tag     = r_buf[r_head];
  assign fl.free_count    = r_spec_cnt;
  assign fl.err_overflow  = r_err_overflow;
  assign fl.err_underflow = r_err_underflow;
endmodule
`default_nettype wire

// File: tb/tb_phys_free_list.sv
// Directed self-checking bench for phys_free_list with NUM_PHYS=16, NUM_ARCH=8.
`default_nettype none
module tb_phys_free_list;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  phys_free_list_if #(.NUM_PHYS(16), .NUM_ARCH(8)) fl ();

  phys_free_list #(.NUM_PHYS(16), .NUM_ARCH(8)) dut (
    .clk (clk),
    .rst (rst),
    .fl  (fl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ret(input logic [3:0] tag);
    fl.ret_valid = 1'b1;
    fl.ret_tag   = tag;
    cyc();
    fl.ret_valid = 1'b0;
  endtask

  task automatic alloc_seq(input string tag, input logic [3:0] t0, input logic [3:0] t1,
                           input logic [3:0] t2, input logic [3:0] t3, input int n);
    logic [3:0] exp [4];
    exp = '{t0, t1, t2, t3};
    fl.alloc_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      check(tag, fl.alloc_tag, exp[i]);
      cyc();
    end
    fl.alloc_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst             = 1'b1;
    fl.alloc_req    = 1'b0;
    fl.ret_valid    = 1'b0;
    fl.ret_tag      = '0;
    fl.commit_alloc = 1'b0;
    fl.recover      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", fl.alloc_valid, 1);
    check("rst_tag", fl.alloc_tag, 8);
    check("rst_count", fl.free_count, 8);
    check("rst_ovf", fl.err_overflow, 0);
    check("rst_unf", fl.err_underflow, 0);
    rst = 1'b0;
    cyc();

    // Drain the whole list back to back.
    fl.alloc_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_tag", fl.alloc_tag, 8 + i);
      check("drain_valid", fl.alloc_valid, 1);
      cyc();
    end
    check("empty_valid", fl.alloc_valid, 0);
    check("empty_count", fl.free_count, 0);
    cyc();
    check("empty_hold", fl.free_count, 0);
    fl.alloc_req = 1'b0;

    fl.commit_alloc = 1'b1;
    repeat (8) cyc();
    fl.commit_alloc = 1'b0;
    check("commit8_unf", fl.err_underflow, 0);

    // Return into an empty list while requesting: no bypass grant.
    fl.alloc_req = 1'b1;
    fl.ret_valid = 1'b1;
    fl.ret_tag   = 4'd3;
    check("nobyp_valid", fl.alloc_valid, 0);
    cyc();
    fl.alloc_req = 1'b0;
    fl.ret_valid = 1'b0;
    check("byp_valid", fl.alloc_valid, 1);
    check("byp_tag", fl.alloc_tag, 3);
    check("byp_count", fl.free_count, 1);

    ret(4'd4); ret(4'd5); ret(4'd6); ret(4'd7); ret(4'd9); ret(4'd10);
    check("refill_count", fl.free_count, 7);
    alloc_seq("out4_tag", 4'd3, 4'd4, 4'd5, 4'd6, 4);
    check("out4_count", fl.free_count, 3);

    // Alloc + return + commit together; the return lands at index 7, tail wraps.
    fl.alloc_req    = 1'b1;
    fl.ret_valid    = 1'b1;
    fl.ret_tag      = 4'd12;
    fl.commit_alloc = 1'b1;
    check("tri_tag", fl.alloc_tag, 7);
    cyc();
    fl.alloc_req    = 1'b0;
    fl.ret_valid    = 1'b0;
    fl.commit_alloc = 1'b0;
    check("tri_count", fl.free_count, 3);
    check("tri_ovf", fl.err_overflow, 0);
    check("tri_unf", fl.err_underflow, 0);
    ret(4'd13);
    check("wrap_count", fl.free_count, 4);
    alloc_seq("wrap_tag", 4'd9, 4'd10, 4'd12, 4'd13, 4);
    check("wrap_empty", fl.alloc_valid, 0);

    fl.recover = 1'b1;
    cyc();
    fl.recover = 1'b0;
    check("rec1_count", fl.free_count, 8);
    check("rec1_tag", fl.alloc_tag, 4);
    fl.commit_alloc = 1'b1;
    cyc();
    fl.commit_alloc = 1'b0;
    check("unf_flag", fl.err_underflow, 1);
    check("unf_count", fl.free_count, 8);

    // Asynchronous reset with three tags outstanding and recover held.
    alloc_seq("pre_rst_tag", 4'd4, 4'd5, 4'd6, 4'd0, 3);
    check("pre_rst_count", fl.free_count, 5);
    fl.recover = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", fl.alloc_valid, 1);
    check("arst_tag", fl.alloc_tag, 8);
    check("arst_count", fl.free_count, 8);
    check("arst_unf", fl.err_underflow, 0);
    check("arst_ovf", fl.err_overflow, 0);
    cyc();
    rst        = 1'b0;
    fl.recover = 1'b0;
    cyc();

    alloc_seq("rec2_alloc", 4'd8, 4'd9, 4'd10, 4'd11, 4);
    fl.commit_alloc = 1'b1;
    repeat (2) cyc();
    fl.commit_alloc = 1'b0;
    check("rec2_pre_count", fl.free_count, 4);
    fl.recover = 1'b1;
    cyc();
    fl.recover = 1'b0;
    check("rec2_count", fl.free_count, 6);
    check("rec2_tag", fl.alloc_tag, 10);

    // Return into a full list is dropped and flagged.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    ret(4'd5);
    check("ovf_flag", fl.err_overflow, 1);
    check("ovf_count", fl.free_count, 8);
    check("ovf_tag", fl.alloc_tag, 8);
    cyc();
    check("ovf_sticky", fl.err_overflow, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/phys_free_list.md
PHYS_FREE_LIST -- requirements
Module: phys_free_list

Interface
REQ-001 SHALL have parameter NUM_PHYS, default 16, total physical register tags.
REQ-002 SHALL have parameter NUM_ARCH, default 8, architectural registers; tags 0..NUM_ARCH-1 are mapped at reset.
REQ-003 SHALL derive local constants TAG_W = $clog2(NUM_PHYS) and FL_SIZE = NUM_PHYS - NUM_ARCH.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 alloc_req  in  1  rename stage requests one tag this cycle.
REQ-008 alloc_valid  out  1  a free tag is available.
REQ-009 alloc_tag  out  TAG_W  tag granted when alloc_req & alloc_valid.
REQ-010 ret_valid  in  1  commit returns a freed tag (driven by commit-side reg_return).
REQ-011 ret_tag  in  TAG_W  tag being returned.
REQ-012 commit_alloc  in  1  oldest speculative allocation became architectural.
REQ-013 recover  in  1  squash: all uncommitted allocations return to the list.
REQ-014 free_count  out  $clog2(FL_SIZE+1)  speculative free-tag count.
REQ-015 err_overflow  out  1  sticky: return attempted while the architectural list was full.
REQ-016 err_underflow  out  1  sticky: commit_alloc with no outstanding speculative allocation.

Function
REQ-017 SHALL store FL_SIZE tags in a circular buffer with spec head (head), commit head (chead) and tail pointers, each wrapping modulo FL_SIZE; FL_SIZE need not be a power of two.
REQ-018 SHALL maintain spec_cnt (entries head..tail) and arch_cnt (entries chead..tail) in registers, with no pointer-equality ambiguity at full.
REQ-019 SHALL drive alloc_valid = (spec_cnt != 0) and alloc_tag = buffer[head], both combinational from registered state (no same-cycle return bypass).
REQ-020 Alloc fire = alloc_req & alloc_valid & ~recover; on fire, head increments and spec_cnt decrements at the next edge.
REQ-021 On ret_valid with arch_cnt < FL_SIZE, SHALL write ret_tag to buffer[tail], increment tail and increment both spec_cnt and arch_cnt.
REQ-022 On ret_valid with arch_cnt == FL_SIZE, SHALL drop the return and set err_overflow.
REQ-023 On commit_alloc with arch_cnt > spec_cnt, SHALL increment chead and decrement arch_cnt; otherwise it SHALL be ignored and err_underflow set.
REQ-024 On recover, SHALL set head <= chead (after any same-cycle commit_alloc) and spec_cnt <= arch_cnt including any same-cycle return; alloc_req is ignored that cycle.
REQ-025 Alloc, return and commit_alloc in the same cycle SHALL all take effect; counts change by the net sum.
REQ-026 free_count SHALL equal spec_cnt.
REQ-027 An empty list with same-cycle alloc_req and ret_valid SHALL grant nothing; the returned tag appears on alloc_tag the next cycle.

Reset
REQ-028 On rst, buffer[i] SHALL equal NUM_ARCH+i; head=chead=tail=0; spec_cnt=arch_cnt=FL_SIZE; alloc_valid=1; alloc_tag=NUM_ARCH; free_count=FL_SIZE; err flags=0.
REQ-029 Reset asserted mid-operation SHALL discard all allocations and returns immediately (asynchronous), regardless of recover.

Structure
REQ-030 NUM_PHYS and NUM_ARCH defaults SHALL come from the shared nand_cpu header macros (`NUM_REG-style); the tag typedef SHALL live in the shared package.
REQ-031 SHALL be a single module with no sub-modules; the pointer increment-with-wrap SHALL be a local function.

Verification (NUM_PHYS=16, NUM_ARCH=8)
REQ-032 After reset, 8 back-to-back allocs -> tags 8..15 granted in order; alloc_valid=0 on the 9th cycle; free_count=0.
REQ-033 Empty list, ret_valid tag 3 with alloc_req high -> no grant that cycle; next cycle alloc_valid=1, alloc_tag=3.
REQ-034 Allocate 8..11, commit_alloc twice, recover -> free_count=6, alloc_tag=10.
REQ-035 Full list after reset, ret_valid tag 5 -> return dropped, err_overflow=1 and stays 1; free_count=8.
REQ-036 Same cycle alloc fire + ret_valid + commit_alloc with 4 tags outstanding -> free_count unchanged, arch_cnt down 1 and up 1 net 0, tail wraps correctly past index 7.
REQ-037 Reset asserted mid-sequence with 3 tags outstanding -> outputs return to REQ-028 values asynchronously.
